// File: rtl/hex_seg_pkg.sv
// rtl/hex_seg_pkg.sv - seven-segment patterns and capture-state type shared by the scan decoder
package hex_seg_pkg;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_9_ALT = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int DP_BIT = 7;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        CAPTURE = 2'd1,
        LOCKED  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/hex_scan_decoder_if.sv
// rtl/hex_scan_decoder_if.sv - decoded-frame valid/ready bundle
// master: decoder side (drives frame, valid, overrun); slave: consumer side (drives out_ready)
interface hex_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] out_value;
    logic [DIGITS-1:0]   out_dp;
    logic                out_err;
    logic                out_valid;
    logic                out_ready;
    logic                overrun;

    modport master (
        output out_value, out_dp, out_err, out_valid, overrun,
        input  out_ready
    );

    modport slave (
        input  out_value, out_dp, out_err, out_valid, overrun,
        output out_ready
    );
endinterface

// File: rtl/seg_to_nibble.sv
// rtl/seg_to_nibble.sv - combinational inverse of the hexEncode segment table
// seg[6:0] in (active-low g..a); nibble[3:0] out; err out (pattern not in table, nibble forced 0)
module seg_to_nibble
    import hex_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);
    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (seg)
            SEG_0:            nibble = 4'h0;
            SEG_1:            nibble = 4'h1;
            SEG_2:            nibble = 4'h2;
            SEG_3:            nibble = 4'h3;
            SEG_4:            nibble = 4'h4;
            SEG_5:            nibble = 4'h5;
            SEG_6:            nibble = 4'h6;
            SEG_7:            nibble = 4'h7;
            SEG_8:            nibble = 4'h8;
            SEG_9, SEG_9_ALT: nibble = 4'h9;
            SEG_A:            nibble = 4'hA;
            SEG_B:            nibble = 4'hB;
            SEG_C:            nibble = 4'hC;
            SEG_D:            nibble = 4'hD;
            SEG_E:            nibble = 4'hE;
            SEG_F:            nibble = 4'hF;
            default:          err    = 1'b1;
        endcase
    end
endmodule

// File: rtl/hex_scan_decoder.sv
// rtl/hex_scan_decoder.sv - reconstructs a multiplexed seven-segment display into hex frames
// clk, rst_n (async active-low); an[DIGITS] digit enables (active-low); hex[8] segments (active-low, [7]=dp)
// frm (master): out_value/out_dp/out_err/out_valid out, out_ready in, overrun one-cycle drop pulse
module hex_scan_decoder
    import hex_seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGITS-1:0]  an,
    input  logic [7:0]         hex,
    hex_scan_decoder_if.master frm
);
    localparam int CW = $clog2(STABLE + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0]   r_an_s1, r_an_s2;
    logic [7:0]          r_hex_s1, r_hex_s2;
    logic [CW-1:0]       r_cnt;
    cap_state_t          r_state;
    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_dp_sh, r_err_sh, r_seen;
    logic [4*DIGITS-1:0] r_out_value;
    logic [DIGITS-1:0]   r_out_dp;
    logic                r_out_err, r_out_valid, r_overrun;

    logic                w_moving;
    logic [IW-1:0]       w_idx;
    logic                w_sample;
    logic [3:0]          w_nib;
    logic                w_seg_err;
    logic [4*DIGITS-1:0] w_shadow_nx;
    logic [DIGITS-1:0]   w_dp_nx, w_err_nx, w_seen_nx;
    logic                w_complete, w_load, w_drop, w_accept;

    seg_to_nibble u_dec (
        .seg    (r_hex_s2[6:0]),
        .nibble (w_nib),
        .err    (w_seg_err)
    );

    // The first stage holds what the bus becomes on the next edge, so comparing
    // stages tells us whether S is about to change.
    assign w_moving = (r_an_s1 != r_an_s2) || (r_hex_s1 != r_hex_s2);

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!r_an_s2[k]) w_idx = IW'(k);
        end
    end

    // Blank or ghosted (multiple digits enabled) buses are ignored.
    assign w_sample = (r_state == CAPTURE) && $onehot(~r_an_s2);

    always_comb begin
        w_shadow_nx = r_shadow;
        w_dp_nx     = r_dp_sh;
        w_err_nx    = r_err_sh;
        w_seen_nx   = r_seen;
        if (w_sample) begin
            w_shadow_nx[4*w_idx +: 4] = w_nib;
            w_dp_nx[w_idx]            = ~r_hex_s2[DP_BIT];
            w_err_nx[w_idx]           = w_seg_err;
            w_seen_nx[w_idx]          = 1'b1;
        end
    end

    // Completion folds in the digit being sampled so the frame emerges on the
    // edge that leaves CAPTURE.
    assign w_complete = w_sample && (&w_seen_nx);
    assign w_accept   = r_out_valid && frm.out_ready;
    assign w_load     = w_complete && (!r_out_valid || frm.out_ready);
    assign w_drop     = w_complete && !w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_s1     <= '1;
            r_an_s2     <= '1;
            r_hex_s1    <= '1;
            r_hex_s2    <= '1;
            r_cnt       <= '0;
            r_state     <= SETTLE;
            r_shadow    <= '0;
            r_dp_sh     <= '0;
            r_err_sh    <= '0;
            r_seen      <= '0;
            r_out_value <= '0;
            r_out_dp    <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_an_s1  <= an;
            r_an_s2  <= r_an_s1;
            r_hex_s1 <= hex;
            r_hex_s2 <= r_hex_s1;

            case (r_state)
                SETTLE: begin
                    if (w_moving) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(STABLE - 1)) r_state <= CAPTURE;
                    end
                end
                CAPTURE: r_state <= LOCKED;
                LOCKED: begin
                    if (w_moving) begin
                        r_state <= SETTLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= SETTLE;
                    r_cnt   <= '0;
                end
            endcase

            if (w_sample) begin
                r_shadow <= w_shadow_nx;
                r_dp_sh  <= w_dp_nx;
            end
            if (w_complete) begin
                r_seen   <= '0;
                r_err_sh <= '0;
            end else if (w_sample) begin
                r_seen   <= w_seen_nx;
                r_err_sh <= w_err_nx;
            end

            if (w_load) begin
                r_out_value <= w_shadow_nx;
                r_out_dp    <= w_dp_nx;
                r_out_err   <= |w_err_nx;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            r_overrun <= w_drop;
        end
    end

    assign frm.out_value = r_out_value;
    assign frm.out_dp    = r_out_dp;
    assign frm.out_err   = r_out_err;
    assign frm.out_valid = r_out_valid;
    assign frm.overrun   = r_overrun;
endmodule

// File: doc/hex_scan_decoder.md
Name: hex_scan_decoder

Overview:
Receive-side counterpart of the team's hexEncode seven-segment encoder. It watches a time-multiplexed, active-low seven-segment display bus (digit enables plus segment lines) and reconstructs the displayed multi-digit hex value. Completed frames are delivered on a valid/ready output. It is used to self-check display drivers in the lab designs and benches.

Parameters:
DIGITS, 4, number of multiplexed digits (an width); legal range 1..8
STABLE, 4, consecutive clock edges the synchronised bus must hold unchanged before a digit is sampled; legal range 2..255

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
an  in  DIGITS  digit enables, active-low; bit k = digit k (digit 0 = least significant nibble)
hex  in  8  segments, active-low; [7]=dp, [6:0]=g..a (hexEncode format)
out_value  out  4*DIGITS  decoded nibbles; digit k at [4k+3:4k]
out_dp  out  DIGITS  decimal point lit per digit (active-high, = ~hex[7] at sample)
out_err  out  1  at least one digit in the frame had an unrecognised pattern
out_valid  out  1  frame available
out_ready  in  1  consumer accepts the frame
overrun  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- One clock domain. Reset is asynchronous, active-low. Clock and reset ports are named clk and rst_n.
- Reset (async assert, sync use after deassert):
  - Synchroniser flops go to all-ones (blank, no digit).
  - Stability counter 0; seen mask 0; shadow registers 0.
  - out_value 0, out_dp 0, out_err 0, out_valid 0, overrun 0.
- Synchroniser: an and hex pass through two flop stages each; the result is the bus value S.
- Capture FSM:
  - SETTLE: a counter increments each edge S equals its previous value, saturating at STABLE. Any change in S clears it and stays in SETTLE.
  - When the counter reaches STABLE, go to CAPTURE for exactly one cycle.
  - CAPTURE always goes to LOCKED.
  - LOCKED: no further samples. Any change in S returns to SETTLE with the counter at 0.
- Sample action in CAPTURE, only when S.an has exactly one zero at position k:
  - shadow[k] = decode(S.hex[6:0]) and dp[k] = ~S.hex[7].
  - err[k] is set if the pattern is not in the table; the nibble is then 0.
  - seen[k] = 1.
  - If S.an is all-ones or has more than one zero, no sample is taken and nothing changes.
- Decode table (hex[6:0]): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10 or 18→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F. Every other pattern, including blank 7F, is an error.
- Resampling a digit before the frame completes overwrites its nibble, dp and err (latest wins).
- Frame complete = seen all-ones, evaluated the cycle after CAPTURE:
  - If out_valid is 0, or out_valid & out_ready in that same cycle: load out_value/out_dp from shadow, out_err = OR of err[], out_valid = 1, clear seen and err[].
  - Else (output held, not accepted): drop the frame, clear seen and err[], overrun = 1 for one cycle. The held output is unchanged.
- Handshake: out_valid stays high with out_value/out_dp/out_err stable until a cycle with out_ready = 1. out_valid falls on the next edge unless a new frame loads in that same cycle, in which case it stays high with the new data.
- Latency: a bus change reaching its final stable value at pins → CAPTURE after 2 + STABLE edges → out_valid one edge later.
- Reset mid-frame: partial seen/shadow is discarded immediately, with no overrun and no output.

Decomposition:
- Package hex_seg_pkg: 7-bit SEG_0..SEG_F constants, SEG_9_ALT (18), SEG_BLANK (7F), DP_BIT = 7, capture-state enum {SETTLE, CAPTURE, LOCKED}.
- Sub-module seg_to_nibble: combinational, seg[6:0] in; nibble[3:0] and err out. Exact inverse of hexEncode.
- Top holds the synchroniser, FSM, shadow, frame and handshake logic.

Test Plan:
1. rst_n = 0 with random an/hex → out_valid 0, out_value 0, out_dp 0, out_err 0, overrun 0, all held for the duration of reset.
2. out_ready = 1; scan an = 0111/1011/1101/1110 with hex A4/88/92/8E, each held 8 cycles → out_valid with out_value 16'h2A5F, out_err 0, out_dp 0000.
3. Digit held 3 cycles (< STABLE) then changed → not sampled; frame completes only after every digit has been held ≥ 4 cycles.
4. Digit 0 = 98, later frame digit 0 = 90 → nibble 9 both times. Digit 1 = FF → nibble 0 and out_err 1. Digit 2 = 7F (dp lit, blank) → out_dp[2] = 1 and out_err 1.
5. out_ready = 0 for two full frames → first frame held unchanged, second dropped with a one-cycle overrun pulse. Raise out_ready → out_valid drops next edge.
6. Assert rst_n mid-frame after two digits are captured → outputs 0 immediately. After release, a fresh full scan produces exactly one correct frame.
